vcounter: RTL and testbench

Vertical timing generator for the VGA display path. It sits directly downstream of the horizontal counter and consumes that counter's `roll` output, a level that is high during each line's active-pixel window. The block counts lines, sequences the vertical phases (active, front porch, sync, back porch) with a state machine, and drives vertical sync, vertical display-enable, a frame-start strobe and the line count to the pixel/framebuffer logic.

---
 rtl/vcounter.sv | 119 +++++++++++
 tb/tb_vcounter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vcounter.sv
// Vertical timing generator: counts lines on falling edges of the horizontal
// roll level and sequences ACT/FP/SYN/BP. Optional frame counter via VCNTR_FRAMECNT_EN.
module vcounter #(
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic       clkv,
  input  logic       clrv,
  input  logic       roll,
  output logic [9:0] cntrv,
  output logic       vd,
  output logic       vde,
  output logic       vblank,
  output logic       fstart
`ifdef VCNTR_FRAMECNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  LastAct = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  LastFp  = 10'(V_FP - 1);
  localparam logic [9:0]  LastSyn = 10'(V_SYNC - 1);
  localparam logic [9:0]  LastBp  = 10'(V_BP - 1);

  typedef enum logic [1:0] {StAct, StFp, StSyn, StBp} state_e;

  state_e     state_q, state_d;
  logic [9:0] pcnt_q, pcnt_d;
  logic [9:0] cntrv_q, cntrv_d;
  logic [9:0] plast;
  logic       roll_q, tick, wrap;
  logic       vde_q, vde_d, vd_q, vd_d, fstart_q;

  // Line ends on the falling edge of the active-window level.
  assign tick = roll_q & ~roll;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    cntrv_d = cntrv_q;
    wrap    = 1'b0;
    plast   = LastAct;
    unique case (state_q)
      StAct: plast = LastAct;
      StFp:  plast = LastFp;
      StSyn: plast = LastSyn;
      StBp:  plast = LastBp;
    endcase
    if (tick) begin
      if (pcnt_q == plast) begin
        pcnt_d = '0;
        unique case (state_q)
          StAct: state_d = StFp;
          StFp:  state_d = StSyn;
          StSyn: state_d = StBp;
          StBp:  state_d = StAct;
        endcase
      end else begin
        pcnt_d = pcnt_q + 10'd1;
      end
      if (cntrv_q == VLast) begin
        cntrv_d = '0;
        wrap    = 1'b1;
      end else begin
        cntrv_d = cntrv_q + 10'd1;
      end
    end
    // Decode from next state so outputs move on the same edge as cntrv.
    vde_d = (state_d == StAct);
    vd_d  = (state_d == StSyn) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge clkv or posedge clrv) begin
    if (clrv) begin
      state_q  <= StAct;
      pcnt_q   <= '0;
      cntrv_q  <= '0;
      roll_q   <= 1'b0;
      vde_q    <= 1'b1;
      vd_q     <= ~V_SYNC_POL;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      cntrv_q  <= cntrv_d;
      roll_q   <= roll;
      vde_q    <= vde_d;
      vd_q     <= vd_d;
      fstart_q <= wrap;
    end
  end

`ifdef VCNTR_FRAMECNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clkv or posedge clrv) begin
    if (clrv) begin
      frame_cnt_q <= '0;
    end else if (wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign cntrv  = cntrv_q;
  assign vde    = vde_q;
  assign vblank = ~vde_q;
  assign vd     = vd_q;
  assign fstart = fstart_q;

endmodule

// File: tb/tb_vcounter.sv
// Scoreboard bench for vcounter: a line-number reference model predicts outputs for a
// default instance and a small overridden instance driven by the same random roll stream.
module tb_vcounter;

  logic       clkv = 1'b0;
  logic       clrv = 1'b1;
  logic       roll = 1'b0;
  logic [9:0] cntrv0, cntrv1;
  logic       vd0, vde0, vblank0, fstart0;
  logic       vd1, vde1, vblank1, fstart1;
  logic [7:0] fc0, fc1;

  always #5 clkv = ~clkv;

  vcounter u_dut0 (
    .clkv     (clkv),
    .clrv     (clrv),
    .roll     (roll),
    .cntrv    (cntrv0),
    .vd       (vd0),
    .vde      (vde0),
    .vblank   (vblank0),
    .fstart   (fstart0)
`ifdef VCNTR_FRAMECNT_EN
    ,
    .frame_cnt(fc0)
`endif
  );

  vcounter #(
    .V_ACTIVE  (4),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .V_SYNC_POL(1'b1)
  ) u_dut1 (
    .clkv     (clkv),
    .clrv     (clrv),
    .roll     (roll),
    .cntrv    (cntrv1),
    .vd       (vd1),
    .vde      (vde1),
    .vblank   (vblank1),
    .fstart   (fstart1)
`ifdef VCNTR_FRAMECNT_EN
    ,
    .frame_cnt(fc1)
`endif
  );

`ifndef VCNTR_FRAMECNT_EN
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
`endif

  // Reference timing for the two instances.
  int a_len[2] = '{480, 4};
  int f_len[2] = '{10, 1};
  int s_len[2] = '{2, 1};
  int b_len[2] = '{33, 1};
  bit pol[2]   = '{1'b0, 1'b1};

  typedef struct {
    int line[2];
    bit vde[2];
    bit vd[2];
    bit fs[2];
    int fc[2];
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  int  line[2];
  bit  fs[2];
  int  fc[2];
  bit  prev;
  int  fs_model[2];
  int  fs_seen[2];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      int sync_lo;
      bit in_sync;
      sync_lo   = a_len[k] + f_len[k];
      in_sync   = (line[k] >= sync_lo) && (line[k] < sync_lo + s_len[k]);
      x.line[k] = line[k];
      x.vde[k]  = line[k] < a_len[k];
      x.vd[k]   = in_sync ? pol[k] : !pol[k];
      x.fs[k]   = fs[k];
      x.fc[k]   = fc[k];
    end
    return x;
  endfunction

  task automatic step(input bit r, input bit c);
    bit tick;
    @(negedge clkv);
    roll = r;
    clrv = c;
    if (c) begin
      prev = 1'b0;
      for (int k = 0; k < 2; k++) begin
        line[k] = 0;
        fs[k]   = 1'b0;
        fc[k]   = 0;
      end
    end else begin
      tick = prev && !r;
      for (int k = 0; k < 2; k++) begin
        int total;
        total = a_len[k] + f_len[k] + s_len[k] + b_len[k];
        if (tick) begin
          line[k] = (line[k] + 1) % total;
          fs[k]   = (line[k] == 0);
          if (fs[k]) begin
            fc[k] = (fc[k] + 1) % 256;
            fs_model[k]++;
          end
        end else begin
          fs[k] = 1'b0;
        end
      end
      prev = r;
    end
    sbq.push_back(predict());
    if (c) begin
      #1;
      check("async_clr_cntrv", int'(cntrv0), 0);
      check("async_clr_vde", int'(vde0), 1);
      check("async_clr_vd", int'(vd0), 1);
      check("async_clr_fstart", int'(fstart0), 0);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  task automatic rand_pulse();
    pulse(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
  endtask

  always @(posedge clkv) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("cntrv0", int'(cntrv0), e.line[0]);
      check("vde0", int'(vde0), int'(e.vde[0]));
      check("vblank0", int'(vblank0), int'(!e.vde[0]));
      check("vd0", int'(vd0), int'(e.vd[0]));
      check("fstart0", int'(fstart0), int'(e.fs[0]));
      check("cntrv1", int'(cntrv1), e.line[1]);
      check("vde1", int'(vde1), int'(e.vde[1]));
      check("vblank1", int'(vblank1), int'(!e.vde[1]));
      check("vd1", int'(vd1), int'(e.vd[1]));
      check("fstart1", int'(fstart1), int'(e.fs[1]));
`ifdef VCNTR_FRAMECNT_EN
      check("frame_cnt0", int'(fc0), e.fc[0]);
      check("frame_cnt1", int'(fc1), e.fc[1]);
`endif
      if (fstart0) fs_seen[0]++;
      if (fstart1) fs_seen[1]++;
    end
  end

  initial begin
    // Reset with roll toggling, then release while roll is high.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    // Three full default frames with random line shapes, including 1-cycle glitches.
    repeat (3 * 525) rand_pulse();
    // Mid-frame reset at line 300.
    while (line[0] != 300) rand_pulse();
    step(1'b1, 1'b1);
    pulse(2, 2);
    // Tightly spaced pulses: tick every 2 cycles.
    repeat (40) pulse(1, 1);
    // Enough small-frame wraps to roll an 8-bit frame counter.
    repeat (256 * 7 + 20) begin
      if ($urandom_range(0, 3) == 0) rand_pulse();
      else pulse(1, 1);
    end
    step(1'b0, 1'b0);
    @(posedge clkv);
    #2;
    check("fstart_count0", fs_seen[0], fs_model[0]);
    check("fstart_count1", fs_seen[1], fs_model[1]);
    check("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
